axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, 32, data width of the bus and command/response data.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, 8, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 256, wait limit per transaction before timeout_err is flagged.
REQ-004 SHALL have port M_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port M_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port cmd_valid  in  1  command offered.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-008 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-009 SHALL have port cmd_addr  in  C_M_AXI_ADDR_WIDTH  target byte address.
REQ-010 SHALL have port cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data (ignored for reads).
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_write  out  1  copy of cmd_write of the completed transaction.
REQ-014 SHALL have port rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
REQ-015 SHALL have port rsp_resp  out  2  BRESP or RRESP of the completed transaction.
REQ-016 SHALL have port timeout_err  out  1  sticky: some transaction waited > TIMEOUT_CYCLES.
REQ-017 SHALL have ports M_AXI_AWADDR out ADDR_W, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1: write address channel.
REQ-018 SHALL have ports M_AXI_WDATA out DATA_W, M_AXI_WVALID out 1, M_AXI_WREADY in 1: write data channel (no strobes; full-word writes).
REQ-019 SHALL have ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write response channel.
REQ-020 SHALL have ports M_AXI_ARADDR out ADDR_W, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1: read address channel.
REQ-021 SHALL have ports M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read data channel.

Function
REQ-022 SHALL use states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP; one transaction outstanding at a time.
REQ-023 SHALL drive cmd_ready = 1 only in IDLE; a command is captured (addr, wdata, write) on the cmd_valid && cmd_ready edge; IDLE -> WR_ADDR_DATA if write, else RD_ADDR.
REQ-024 SHALL assert AWVALID and WVALID together from the cycle after capture, each dropped independently on the edge its own READY is seen; exit WR_ADDR_DATA to WR_RESP once both handshakes are done (same cycle or any order, WREADY arriving before AWREADY included).
REQ-025 SHALL hold AWADDR/WDATA/ARADDR stable while the corresponding VALID is high; VALID SHALL never depend combinationally on READY.
REQ-026 SHALL assert BREADY in WR_RESP; on BVALID capture BRESP into rsp_resp, rsp_rdata = 0, go to RESP.
REQ-027 SHALL assert ARVALID in RD_ADDR until ARREADY, then RD_DATA with RREADY = 1; on RVALID capture RDATA/RRESP, go to RESP.
REQ-028 SHALL assert rsp_valid in RESP, holding rsp_* stable until rsp_ready, then return to IDLE; command-to-first-VALID latency 1 cycle, response visible 1 cycle after final handshake.
REQ-029 SHALL count cycles spent outside IDLE/RESP per transaction (counter clears on capture, saturates); at count == TIMEOUT_CYCLES set timeout_err, which stays set until reset; the transaction SHALL continue waiting (no VALID withdrawn).
REQ-030 SHALL pass any RESP code (OKAY/EXOKAY/SLVERR/DECERR) through unmodified.

Reset
REQ-031 SHALL, while M_AXI_ARESET is high at a clock edge, go to IDLE and drive all VALID/READY outputs 0, rsp_* 0, timeout_err 0, addresses/data 0, counter 0; reset mid-transaction abandons it with no response.

Structure
REQ-032 SHALL take the state enum and AXI response code constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) from a shared package axi_lite_pkg.
REQ-033 SHALL be a single module; no sub-module required.

Verification
REQ-034 Write 0x10 <= 0xDEADBEEF, slave AWREADY 2 cycles then WREADY 2 cycles later, BRESP 00 -> one AW and one W handshake, rsp_valid with rsp_write=1, rsp_resp=00, rsp_rdata=0.
REQ-035 Read 0x40, slave returns RDATA 0x12345678 RRESP 00 after 3-cycle ARREADY delay -> rsp_rdata=0x12345678, rsp_write=0, ARVALID held stable until accepted.
REQ-036 Write with WREADY asserted before AWREADY, and one with both same cycle -> exactly one handshake per channel, then WR_RESP.
REQ-037 rsp_ready low for 5 cycles with cmd_valid high -> cmd_ready stays 0, rsp_* stable; next command accepted the cycle after rsp_ready.
REQ-038 Slave never asserts BVALID, TIMEOUT_CYCLES=16 -> timeout_err set after 16 waiting cycles, BREADY held; later BVALID with BRESP 10 completes with rsp_resp=10.
REQ-039 Reset asserted during RD_DATA -> next cycle all VALID/READY 0, state IDLE, cmd_ready 1 after release, no rsp_valid.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: controller states and response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle (no strobes, no prot) with master and slave views.
interface axi_lite_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns cmd_* requests into bus transactions
// and returns the completion on rsp_*, flagging any transaction that stalls too long.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          timeout_err,
    axi_lite_master_if.master             m_axi
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;
    logic                            rsp_write_q, rsp_write_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;
    logic                            waiting;

    // Bus outputs decode only registered state, never the incoming READYs.
    assign cmd_ready     = (state_q == IDLE) && !M_AXI_ARESET;
    assign m_axi.awvalid = (state_q == WR_ADDR_DATA) && !aw_done_q;
    assign m_axi.wvalid  = (state_q == WR_ADDR_DATA) && !w_done_q;
    assign m_axi.bready  = (state_q == WR_RESP);
    assign m_axi.arvalid = (state_q == RD_ADDR);
    assign m_axi.rready  = (state_q == RD_DATA);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = wdata_q;

    assign rsp_valid   = (state_q == RESP);
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign timeout_err = err_q;

    assign waiting = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                     (state_q == RD_ADDR)      || (state_q == RD_DATA);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        // Saturated count only raises the flag; the transaction keeps waiting.
        if (waiting) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    rsp_write_d = cmd_write;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                aw_done_d = aw_done_q | m_axi.awready;
                w_done_d  = w_done_q | m_axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi.bresp;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                if (m_axi.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi.rvalid) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axi.rdata;
                    rsp_resp_d  = m_axi.rresp;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master acting as a scripted AXI4-Lite slave.
module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int aw_hs = 0;
    int w_hs  = 0;
    int aw_base;
    int w_base;

    axi_lite_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .timeout_err (timeout_err),
        .m_axi       (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.awvalid && bus.awready) aw_hs <= aw_hs + 1;
        if (bus.wvalid && bus.wready)   w_hs  <= w_hs + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0;
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;

        // Reset state
        tick(); tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_awaddr", 32'(bus.awaddr), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write 0x10 <= DEADBEEF, AWREADY after 2 cycles, WREADY 2 cycles later
        aw_base = aw_hs; w_base = w_hs;
        issue(1'b1, 8'h10, 32'hDEADBEEF);
        check("w1_awvalid", 32'(bus.awvalid), 32'd1);
        check("w1_wvalid", 32'(bus.wvalid), 32'd1);
        check("w1_awaddr", 32'(bus.awaddr), 32'h10);
        check("w1_wdata", bus.wdata, 32'hDEADBEEF);
        check("w1_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        check("w1_aw_dropped", 32'(bus.awvalid), 32'd0);
        check("w1_w_held", 32'(bus.wvalid), 32'd1);
        check("w1_wdata_held", bus.wdata, 32'hDEADBEEF);
        tick();
        bus.wready = 1'b1;
        tick();
        bus.wready = 1'b0;
        check("w1_wvalid_dropped", 32'(bus.wvalid), 32'd0);
        check("w1_bready", 32'(bus.bready), 32'd1);
        bus.bvalid = 1'b1; bus.bresp = 2'b00;
        tick();
        bus.bvalid = 1'b0;
        check("w1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("w1_rsp_write", 32'(rsp_write), 32'd1);
        check("w1_rsp_resp", 32'(rsp_resp), 32'd0);
        check("w1_rsp_rdata", rsp_rdata, 32'd0);
        check("w1_bready_off", 32'(bus.bready), 32'd0);
        check("w1_aw_count", 32'(aw_hs - aw_base), 32'd1);
        check("w1_w_count", 32'(w_hs - w_base), 32'd1);
        consume();
        check("w1_done_rsp_valid", 32'(rsp_valid), 32'd0);
        check("w1_done_cmd_ready", 32'(cmd_ready), 32'd1);

        // Read 0x40, ARREADY after 3 cycles, RDATA 12345678 OKAY
        issue(1'b0, 8'h40, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            check("r1_arvalid_held", 32'(bus.arvalid), 32'd1);
            check("r1_araddr_held", 32'(bus.araddr), 32'h40);
            tick();
        end
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("r1_arvalid_off", 32'(bus.arvalid), 32'd0);
        check("r1_rready", 32'(bus.rready), 32'd1);
        bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.rresp = 2'b00;
        tick();
        bus.rvalid = 1'b0;
        check("r1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("r1_rsp_rdata", rsp_rdata, 32'h12345678);
        check("r1_rsp_write", 32'(rsp_write), 32'd0);
        check("r1_rsp_resp", 32'(rsp_resp), 32'd0);
        consume();

        // Write with WREADY ahead of AWREADY, EXOKAY passed through
        aw_base = aw_hs; w_base = w_hs;
        issue(1'b1, 8'h20, 32'hA5A5A5A5);
        bus.wready = 1'b1;
        tick();
        bus.wready = 1'b0;
        check("w2_wvalid_off", 32'(bus.wvalid), 32'd0);
        check("w2_awvalid_on", 32'(bus.awvalid), 32'd1);
        check("w2_no_bready", 32'(bus.bready), 32'd0);
        tick();
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        check("w2_bready", 32'(bus.bready), 32'd1);
        check("w2_aw_count", 32'(aw_hs - aw_base), 32'd1);
        check("w2_w_count", 32'(w_hs - w_base), 32'd1);
        bus.bvalid = 1'b1; bus.bresp = 2'b01;
        tick();
        bus.bvalid = 1'b0;
        check("w2_rsp_resp", 32'(rsp_resp), 32'd1);
        consume();

        // Write with both READYs in one cycle, DECERR; response back-pressured
        aw_base = aw_hs; w_base = w_hs;
        issue(1'b1, 8'h24, 32'h0BADF00D);
        bus.awready = 1'b1; bus.wready = 1'b1;
        tick();
        bus.awready = 1'b0; bus.wready = 1'b0;
        check("w3_bready", 32'(bus.bready), 32'd1);
        check("w3_aw_count", 32'(aw_hs - aw_base), 32'd1);
        check("w3_w_count", 32'(w_hs - w_base), 32'd1);
        bus.bvalid = 1'b1; bus.bresp = 2'b11;
        tick();
        bus.bvalid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = '0;
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_resp", 32'(rsp_resp), 32'd3);
            check("bp_rsp_write", 32'(rsp_write), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_released_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp_released_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("bp_next_arvalid", 32'(bus.arvalid), 32'd1);
        check("bp_next_araddr", 32'(bus.araddr), 32'h44);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 32'hCAFEF00D; bus.rresp = 2'b10;
        tick();
        bus.rvalid = 1'b0;
        check("r2_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        check("r2_rsp_resp", 32'(rsp_resp), 32'd2);
        consume();

        // Timeout: slave withholds BVALID well beyond 16 cycles
        check("to_clear_before", 32'(timeout_err), 32'd0);
        issue(1'b1, 8'h30, 32'h11112222);
        bus.awready = 1'b1; bus.wready = 1'b1;
        tick();
        bus.awready = 1'b0; bus.wready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("to_not_yet", 32'(timeout_err), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("to_flagged", 32'(timeout_err), 32'd1);
        check("to_bready_held", 32'(bus.bready), 32'd1);
        bus.bvalid = 1'b1; bus.bresp = 2'b10;
        tick();
        bus.bvalid = 1'b0;
        check("to_rsp_valid", 32'(rsp_valid), 32'd1);
        check("to_rsp_resp", 32'(rsp_resp), 32'd2);
        consume();
        check("to_sticky", 32'(timeout_err), 32'd1);

        // Reset in RD_DATA abandons the read
        issue(1'b0, 8'h80, 32'd0);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("rr_rready", 32'(bus.rready), 32'd1);
        rst = 1'b1;
        tick();
        check("rr_rready_off", 32'(bus.rready), 32'd0);
        check("rr_arvalid_off", 32'(bus.arvalid), 32'd0);
        check("rr_bready_off", 32'(bus.bready), 32'd0);
        check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rr_timeout_cleared", 32'(timeout_err), 32'd0);
        check("rr_rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();
        check("rr_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        check("rr_no_rsp", 32'(rsp_valid), 32'd0);
        check("rr_no_awvalid", 32'(bus.awvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
